pin_verifier: RTL and testbench

PIN_VERIFIER -- requirements
Module: pin_verifier

---
 rtl/pin_verifier.sv | 149 ++++++++++++++
 tb/tb_pin_verifier.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_verifier.sv
`default_nettype none
// =============================================================================
// pin_verifier : per-user PIN check against an external 1-cycle ROM, with
//                consecutive-failure lockout.        Revision 1.0
// =============================================================================
module pin_verifier #(
  parameter  int DIGITS      = 6,
  parameter  int DIGIT_W     = 4,
  parameter  int ID_W        = 3,
  parameter  int MAX_TRIES   = 3,
  parameter  int LOCK_CYCLES = 1000,
  localparam int IDX_W       = $clog2(DIGITS),
  localparam int ADDR_W      = ID_W + IDX_W,
  localparam int TRIES_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ID_W-1:0]    user_id,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               abort,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DIGIT_W-1:0] rom_data,
  output logic               ready,
  output logic               logged_in,
  output logic               locked,
  output logic [DIGITS-1:0]  progress,
  output logic               fail_pulse,
  output logic [TRIES_W-1:0] tries
);

  localparam int                 LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);
  localparam logic [LOCK_W-1:0]  LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    GRANT   = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     uid;
  logic [IDX_W-1:0]    idx;
  logic [LOCK_W-1:0]   lock_cnt;
  logic [TRIES_W-1:0]  tries_inc;

  // Address is a pure concatenation of registers, so it is stable from FETCH through WAIT.
  assign rom_addr  = {uid, idx};
  assign tries_inc = (tries == TRIES_MAX) ? tries : tries + TRIES_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      uid        <= '0;
      idx        <= '0;
      lock_cnt   <= '0;
      tries      <= '0;
      ready      <= 1'b0;
      logged_in  <= 1'b0;
      locked     <= 1'b0;
      progress   <= '0;
      fail_pulse <= 1'b0;
    end else begin
      fail_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (abort) begin
            progress <= '0;
            idx      <= '0;
          end else if (start) begin
            uid      <= user_id;
            idx      <= '0;
            progress <= '0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (abort) begin
            progress <= '0;
            idx      <= '0;
            state    <= IDLE;
          end else begin
            ready <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            ready    <= 1'b0;
            progress <= '0;
            idx      <= '0;
            state    <= IDLE;
          end else if (digit_valid) begin
            ready <= 1'b0;
            if (digit_in == rom_data) begin
              progress[idx] <= 1'b1;
              if (idx == LAST_IDX) begin
                logged_in <= 1'b1;
                tries     <= '0;
                state     <= GRANT;
              end else begin
                idx   <= idx + IDX_W'(1);
                state <= FETCH;
              end
            end else begin
              fail_pulse <= 1'b1;
              progress   <= '0;
              idx        <= '0;
              tries      <= tries_inc;
              if (tries_inc == TRIES_MAX) begin
                locked   <= 1'b1;
                lock_cnt <= LOCK_LOAD;
                state    <= LOCKOUT;
              end else begin
                state <= FETCH;
              end
            end
          end
        end
        GRANT: begin
          if (abort) begin
            logged_in <= 1'b0;
            progress  <= '0;
            idx       <= '0;
            state     <= IDLE;
          end
        end
        LOCKOUT: begin
          // Loaded with LOCK_CYCLES-1 so the state spans exactly LOCK_CYCLES cycles.
          if (lock_cnt == '0) begin
            locked <= 1'b0;
            tries  <= '0;
            state  <= IDLE;
          end else begin
            lock_cnt <= lock_cnt - LOCK_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pin_verifier.sv
`default_nettype none
// =============================================================================
// tb_pin_verifier : directed + random checks of pin_verifier against a
//                   behavioural session model.        Revision 1.0
// =============================================================================
module tb_pin_verifier;

  localparam int D      = 6;
  localparam int DW     = 4;
  localparam int IW     = 3;
  localparam int MT     = 3;
  localparam int LC     = 25;
  localparam int IDX_W  = $clog2(D);
  localparam int ADDR_W = IW + IDX_W;
  localparam int TW     = $clog2(MT + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0, digit_valid = 1'b0, abort = 1'b0;
  logic [IW-1:0]     user_id = '0;
  logic [DW-1:0]     digit_in = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DW-1:0]     rom_data = '0;
  logic              ready, logged_in, locked, fail_pulse;
  logic [D-1:0]      progress;
  logic [TW-1:0]     tries;

  // Second build: 4 digits of 8 bits.
  logic              start4 = 1'b0, dv4 = 1'b0, abort4 = 1'b0;
  logic [IW-1:0]     uid4 = '0;
  logic [7:0]        din4 = '0, rom_data4 = '0;
  logic [IW+1:0]     rom_addr4;
  logic              ready4, logged_in4, locked4, fail4;
  logic [3:0]        progress4;
  logic [1:0]        tries4;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] pin [2**IW][D];

  pin_verifier #(.DIGITS(D), .DIGIT_W(DW), .ID_W(IW), .MAX_TRIES(MT), .LOCK_CYCLES(LC)) u_dut (
    .clk(clk), .rst(rst), .start(start), .user_id(user_id), .digit_valid(digit_valid),
    .digit_in(digit_in), .abort(abort), .rom_addr(rom_addr), .rom_data(rom_data),
    .ready(ready), .logged_in(logged_in), .locked(locked), .progress(progress),
    .fail_pulse(fail_pulse), .tries(tries)
  );

  pin_verifier #(.DIGITS(4), .DIGIT_W(8), .ID_W(IW), .MAX_TRIES(3), .LOCK_CYCLES(10)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .user_id(uid4), .digit_valid(dv4),
    .digit_in(din4), .abort(abort4), .rom_addr(rom_addr4), .rom_data(rom_data4),
    .ready(ready4), .logged_in(logged_in4), .locked(locked4), .progress(progress4),
    .fail_pulse(fail4), .tries(tries4)
  );

  always #5 clk = ~clk;

  // ROMs with one cycle of read latency.
  always @(posedge clk) begin
    rom_data  <= pin[rom_addr[ADDR_W-1:IDX_W]][rom_addr[IDX_W-1:0]];
    rom_data4 <= 8'(int'(rom_addr4) * 37 + 5);
  end

  // Session model: what the user has achieved so far, not how the FSM encodes it.
  bit        m_open, m_fetch, m_grant, m_fail;
  int        m_lock, m_tries, m_pos, m_uid;
  logic [D-1:0] m_prog;

  task automatic model_reset();
    m_open = 0; m_fetch = 0; m_grant = 0; m_fail = 0;
    m_lock = 0; m_tries = 0; m_pos = 0; m_uid = 0; m_prog = '0;
  endtask

  task automatic model_step(input bit s, input int u, input bit v, input int d, input bit a);
    m_fail = 0;
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_tries = 0;
    end else if (m_grant) begin
      if (a) begin m_grant = 0; m_prog = '0; end
    end else if (!m_open) begin
      if (a) m_prog = '0;
      else if (s) begin m_uid = u; m_pos = 0; m_prog = '0; m_open = 1; m_fetch = 1; end
    end else if (a) begin
      m_open = 0; m_prog = '0; m_pos = 0;
    end else if (m_fetch) begin
      m_fetch = 0;
    end else if (v) begin
      if (d == int'(pin[m_uid][m_pos])) begin
        m_prog[m_pos] = 1'b1;
        if (m_pos == D - 1) begin m_open = 0; m_grant = 1; m_tries = 0; end
        else begin m_pos++; m_fetch = 1; end
      end else begin
        m_fail = 1; m_prog = '0; m_pos = 0; m_tries++;
        if (m_tries == MT) begin m_open = 0; m_lock = LC; end
        else m_fetch = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("ready",      64'(ready),      64'(m_open && !m_fetch));
    check("logged_in",  64'(logged_in),  64'(m_grant));
    check("locked",     64'(locked),     64'(m_lock > 0));
    check("progress",   64'(progress),   64'(m_prog));
    check("fail_pulse", 64'(fail_pulse), 64'(m_fail));
    check("tries",      64'(tries),      64'(m_tries));
    if (m_open) check("rom_addr", 64'(rom_addr), 64'(m_uid * (2**IDX_W) + m_pos));
  endtask

  // Called at a falling edge; applies inputs across one rising edge and checks.
  task automatic cycle(input bit s, input int u, input bit v, input int d, input bit a);
    start = s; user_id = IW'(u); digit_valid = v; digit_in = DW'(d); abort = a;
    model_step(s, u, v, d, a);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic enter_digit(input int d);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, d, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_logged_in", 64'(logged_in), 64'(0));
    check("rst_locked",    64'(locked),    64'(0));
    check("rst_ready",     64'(ready),     64'(0));
    check("rst_fail",      64'(fail_pulse), 64'(0));
    check("rst_progress",  64'(progress),  64'(0));
    check("rst_tries",     64'(tries),     64'(0));
    check("rst_rom_addr",  64'(rom_addr),  64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    compare_all();
  endtask

  initial begin
    int n;
    for (int u = 0; u < 2**IW; u++)
      for (int k = 0; k < D; k++)
        pin[u][k] = DW'($urandom_range(0, 15));
    for (int k = 0; k < D; k++) pin[2][k] = DW'(k + 1);
    model_reset();

    repeat (2) @(negedge clk);
    do_reset();

    // Full login for user 2, then log out.
    cycle(1, 2, 0, 0, 0);
    for (int k = 0; k < D; k++) enter_digit(k + 1);
    check("login_logged_in", 64'(logged_in), 64'(1));
    check("login_progress",  64'(progress),  64'({D{1'b1}}));
    check("login_tries",     64'(tries),     64'(0));
    cycle(1, 4, 1, 1, 0);
    check("grant_ignores_start", 64'(logged_in), 64'(1));
    cycle(0, 0, 0, 0, 1);
    check("logout", 64'(logged_in), 64'(0));
    check("logout_progress", 64'(progress), 64'(0));

    // First digit right, second wrong.
    cycle(1, 2, 0, 0, 0);
    enter_digit(1);
    enter_digit(9);
    check("wrong_fail_pulse", 64'(fail_pulse), 64'(1));
    check("wrong_progress",   64'(progress),   64'(0));
    check("wrong_tries",      64'(tries),      64'(1));
    check("wrong_rom_addr",   64'(rom_addr),   64'(2 * (2**IDX_W)));
    cycle(0, 0, 0, 0, 0);
    check("fail_one_cycle",   64'(fail_pulse), 64'(0));

    // Two more wrong entries reach lockout; count the locked cycles.
    cycle(0, 0, 1, 9, 0);
    enter_digit(9);
    check("lock_enter", 64'(locked), 64'(1));
    n = 0;
    while (locked === 1'b1 && n < 2 * LC) begin
      n++;
      cycle(1, 3, 1, 0, 1);
    end
    check("lock_len",   64'(n),     64'(LC));
    check("lock_tries", 64'(tries), 64'(0));
    cycle(0, 0, 0, 0, 0);
    check("lock_idle_ready", 64'(ready), 64'(0));

    // Digit during FETCH is dropped; digit with abort is discarded.
    cycle(1, 2, 0, 0, 0);
    enter_digit(7);
    cycle(0, 0, 1, 2, 0);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 2, 0);
    check("fetch_digit_dropped", 64'(progress), 64'(1));
    cycle(0, 0, 1, 2, 1);
    check("abort_wins_progress", 64'(progress), 64'(0));
    check("abort_wins_tries",    64'(tries),    64'(1));
    check("abort_wins_ready",    64'(ready),    64'(0));

    // Reset mid-entry, then an immediate restart.
    cycle(1, 2, 0, 0, 0);
    for (int k = 0; k < 4; k++) enter_digit(k + 1);
    do_reset();
    cycle(1, 5, 0, 0, 0);
    check("restart_rom_addr", 64'(rom_addr), 64'(5 * (2**IDX_W)));
    cycle(0, 0, 0, 0, 0);
    check("restart_ready", 64'(ready), 64'(1));

    // Randomised sessions.
    for (int i = 0; i < 3000; i++) begin
      int d;
      if (m_open && !m_fetch && $urandom_range(0, 99) < 85) d = int'(pin[m_uid][m_pos]);
      else d = int'($urandom_range(0, 15));
      cycle(($urandom_range(0, 3) == 0), int'($urandom_range(0, 2**IW - 1)),
            $urandom_range(0, 1) == 1, d, ($urandom_range(0, 24) == 0));
      if (i == 1500) do_reset();
    end
    cycle(0, 0, 0, 0, 1);

    // Four-digit, eight-bit build: user 1 logs in.
    start4 = 1'b1; uid4 = 3'd1;
    cycle(0, 0, 0, 0, 0);
    start4 = 1'b0; uid4 = 3'd6;
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0, 0);
      dv4 = 1'b1; din4 = 8'((4 + k) * 37 + 5);
      cycle(0, 0, 0, 0, 0);
      dv4 = 1'b0;
    end
    check("w8_logged_in", 64'(logged_in4), 64'(1));
    check("w8_progress",  64'(progress4),  64'(4'hF));
    check("w8_tries",     64'(tries4),     64'(0));
    abort4 = 1'b1;
    cycle(0, 0, 0, 0, 0);
    abort4 = 1'b0;
    check("w8_logout", 64'(logged_in4), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
